// File: rtl/ddr_frame_arbiter_if.sv
// ddr_frame_arbiter_if: DDR command port bundle between the frame arbiter and the DDR controller
interface ddr_frame_arbiter_if #(
  parameter int ADDR_W = 28
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic              burst_done;
  modport master (output cmd_valid, cmd_write, cmd_addr, cmd_len, input cmd_ready, burst_done);
  modport slave  (input cmd_valid, cmd_write, cmd_addr, cmd_len, output cmd_ready, burst_done);
endinterface

// File: rtl/ddr_frame_arbiter.sv
// ddr_frame_arbiter: triple-buffered frame store scheduler arbitrating camera writes and HDMI reads onto one DDR command port
module ddr_frame_arbiter #(
  parameter int          ADDR_W       = 28,
  parameter int          BURST_LEN    = 64,
  parameter int          BEAT_BYTES   = 16,
  parameter int          FRAME_BURSTS = 4050,
  parameter int unsigned FB_BASE      = 0,
  parameter int unsigned FB_STRIDE    = 32'h0040_0000
) (
  input  logic                core_clk,
  input  logic                rst,
  input  logic                wr_frame_start,
  input  logic                wr_req,
  input  logic                rd_frame_start,
  input  logic                rd_req,
  output logic [1:0]          wr_buf_idx,
  output logic [1:0]          rd_buf_idx,
  output logic                frame_drop,
  ddr_frame_arbiter_if.master cmd
);
  localparam int OFF_W = $clog2(FRAME_BURSTS + 1);
  localparam int SHIFT = $clog2(BURST_LEN * BEAT_BYTES);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
  state_t             r_state, w_state_n;
  logic [1:0]         r_wr_buf, r_rd_buf, r_latest;
  logic [OFF_W-1:0]   r_wr_off, r_rd_off;
  logic               r_last_wr, r_cmd_write, r_wr_pend, r_rd_pend, r_frame_drop;
  logic [ADDR_W-1:0]  r_cmd_addr;
  logic               w_wr_busy, w_rd_busy, w_done, w_wr_go, w_rd_go;
  logic               w_wr_el, w_rd_el, w_grant, w_pick_wr, w_full;
  logic [1:0]         w_rd_buf_n, w_latest_n, w_free;
  function automatic logic [ADDR_W-1:0] buf_addr(input logic [1:0] b, input logic [OFF_W-1:0] o);
    logic [ADDR_W-1:0] base;
    base = b == 2'd0 ? ADDR_W'(FB_BASE) : b == 2'd1 ? ADDR_W'(FB_BASE + FB_STRIDE) : ADDR_W'(FB_BASE + 2 * FB_STRIDE);
    return base + (ADDR_W'(o) << SHIFT);
  endfunction
  assign w_wr_busy  = r_state != IDLE && r_cmd_write;
  assign w_rd_busy  = r_state != IDLE && !r_cmd_write;
  assign w_done     = r_state == WAIT_DONE && cmd.burst_done;
  // a frame start on a busy channel waits for that channel's burst_done
  assign w_wr_go    = (wr_frame_start || r_wr_pend) && (!w_wr_busy || w_done);
  assign w_rd_go    = (rd_frame_start || r_rd_pend) && (!w_rd_busy || w_done);
  assign w_wr_el    = wr_req && r_wr_off < OFF_W'(FRAME_BURSTS) && !w_wr_go;
  assign w_rd_el    = rd_req && r_rd_off < OFF_W'(FRAME_BURSTS) && !w_rd_go;
  assign w_grant    = r_state == IDLE && (w_wr_el || w_rd_el);
  assign w_pick_wr  = w_wr_el && (!w_rd_el || !r_last_wr);
  assign w_full     = r_wr_off == OFF_W'(FRAME_BURSTS);
  assign w_rd_buf_n = w_rd_go ? r_latest : r_rd_buf;
  assign w_latest_n = w_wr_go && w_full ? r_wr_buf : r_latest;
  assign w_free     = (w_latest_n != 2'd0 && w_rd_buf_n != 2'd0) ? 2'd0 :
                      (w_latest_n != 2'd1 && w_rd_buf_n != 2'd1) ? 2'd1 : 2'd2;
  always_comb begin
    w_state_n = r_state;
    w_state_n = w_grant ? ISSUE : (r_state == ISSUE && cmd.cmd_ready) ? WAIT_DONE : w_done ? IDLE : r_state;
  end
  always_ff @(posedge core_clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end
  always_ff @(posedge core_clk) begin
    if (rst) begin
      r_wr_buf     <= 2'd0;
      r_rd_buf     <= 2'd2;
      r_latest     <= 2'd2;
      r_wr_off     <= '0;
      r_rd_off     <= '0;
      r_last_wr    <= 1'b1;
      r_cmd_write  <= 1'b0;
      r_cmd_addr   <= '0;
      r_wr_pend    <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_frame_drop <= 1'b0;
    end else begin
      if (w_grant) begin
        r_cmd_write <= w_pick_wr;
        r_last_wr   <= w_pick_wr;
        r_cmd_addr  <= w_pick_wr ? buf_addr(r_wr_buf, r_wr_off) : buf_addr(r_rd_buf, r_rd_off);
      end
      r_wr_pend    <= (wr_frame_start || r_wr_pend) && !w_wr_go;
      r_rd_pend    <= (rd_frame_start || r_rd_pend) && !w_rd_go;
      r_wr_off     <= w_wr_go ? '0 : (w_done && r_cmd_write) ? r_wr_off + OFF_W'(1) : r_wr_off;
      r_rd_off     <= w_rd_go ? '0 : (w_done && !r_cmd_write) ? r_rd_off + OFF_W'(1) : r_rd_off;
      r_rd_buf     <= w_rd_buf_n;
      r_latest     <= w_latest_n;
      r_wr_buf     <= w_wr_go && w_full ? w_free : r_wr_buf;
      r_frame_drop <= w_wr_go && !w_full;
    end
  end
  assign cmd.cmd_valid = r_state == ISSUE;
  assign cmd.cmd_write = r_cmd_write;
  assign cmd.cmd_addr  = r_cmd_addr;
  assign cmd.cmd_len   = 8'(BURST_LEN - 1);
  assign wr_buf_idx    = r_wr_buf;
  assign rd_buf_idx    = r_rd_buf;
  assign frame_drop    = r_frame_drop;
endmodule

// File: tb/tb_ddr_frame_arbiter.sv
// tb_ddr_frame_arbiter: table, directed and randomized checks of ddr_frame_arbiter against a reference model
module tb_ddr_frame_arbiter;
  localparam int FB = 4050;
  localparam int STRIDE = 32'h0040_0000;
  logic core_clk = 0, rst = 1;
  logic wr_frame_start = 0, wr_req = 0, rd_frame_start = 0, rd_req = 0;
  logic [1:0] wr_buf_idx, rd_buf_idx;
  logic frame_drop;
  ddr_frame_arbiter_if #(.ADDR_W(28)) cmd ();
  ddr_frame_arbiter dut (
    .core_clk(core_clk), .rst(rst), .wr_frame_start(wr_frame_start), .wr_req(wr_req),
    .rd_frame_start(rd_frame_start), .rd_req(rd_req), .wr_buf_idx(wr_buf_idx),
    .rd_buf_idx(rd_buf_idx), .frame_drop(frame_drop), .cmd(cmd)
  );
  always #5 core_clk = ~core_clk;
  int n_vec = 0, n_bad = 0;
  bit chk_en = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  int m_phase, m_addr, m_wrb, m_rdb, m_lat, m_wo, m_ro;
  bit m_is_wr, m_last_wr, m_wp, m_rp, m_drop;
  bit t_done, t_wnow, t_rnow, t_we, t_re, t_pick;
  always @(posedge core_clk) begin
    if (rst) begin
      m_phase = 0; m_addr = 0; m_wrb = 0; m_rdb = 2; m_lat = 2; m_wo = 0; m_ro = 0;
      m_is_wr = 0; m_last_wr = 1; m_wp = 0; m_rp = 0; m_drop = 0;
    end else begin
      t_done = m_phase == 2 && cmd.burst_done;
      t_wnow = (wr_frame_start || m_wp) && !(m_phase != 0 && m_is_wr && !t_done);
      t_rnow = (rd_frame_start || m_rp) && !(m_phase != 0 && !m_is_wr && !t_done);
      m_wp = (wr_frame_start || m_wp) && !t_wnow;
      m_rp = (rd_frame_start || m_rp) && !t_rnow;
      m_drop = 0;
      if (m_phase == 0) begin
        t_we = wr_req && m_wo < FB && !t_wnow;
        t_re = rd_req && m_ro < FB && !t_rnow;
        if (t_we || t_re) begin
          t_pick = t_we && !(t_re && m_last_wr);
          m_is_wr = t_pick;
          m_last_wr = t_pick;
          m_addr = (t_pick ? m_wrb * STRIDE + m_wo * 1024 : m_rdb * STRIDE + m_ro * 1024) & 32'h0FFF_FFFF;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (cmd.cmd_ready) m_phase = 2;
      end else if (t_done) begin
        m_phase = 0;
        if (m_is_wr && !t_wnow) m_wo++;
        if (!m_is_wr && !t_rnow) m_ro++;
      end
      if (t_rnow) begin
        m_rdb = m_lat;
        m_ro = 0;
      end
      if (t_wnow) begin
        if (m_wo == FB) begin
          m_lat = m_wrb;
          for (int b = 2; b >= 0; b--) if (b != m_lat && b != m_rdb) m_wrb = b;
        end else m_drop = 1;
        m_wo = 0;
      end
    end
  end
  always @(negedge core_clk) begin
    if (chk_en) begin
      check("cmd_valid", cmd.cmd_valid, m_phase == 1);
      check("cmd_write", cmd.cmd_write, m_is_wr);
      check("cmd_addr", cmd.cmd_addr, m_addr);
      check("wr_buf_idx", wr_buf_idx, m_wrb);
      check("rd_buf_idx", rd_buf_idx, m_rdb);
      check("frame_drop", frame_drop, m_drop);
      check("buf_overlap", wr_buf_idx != rd_buf_idx, 1);
    end
  end
  task automatic wait_valid();
    int t = 0;
    while (!cmd.cmd_valid && t < 50) begin
      @(negedge core_clk);
      t++;
    end
    if (!cmd.cmd_valid) check("cmd_valid_timeout", cmd.cmd_valid, 1);
  endtask
  task automatic burst(input int lat, output logic w, output logic [27:0] a);
    wait_valid();
    w = cmd.cmd_write;
    a = cmd.cmd_addr;
    cmd.cmd_ready = 1;
    @(negedge core_clk);
    cmd.cmd_ready = 0;
    repeat (lat - 1) @(negedge core_clk);
    cmd.burst_done = 1;
    @(negedge core_clk);
    cmd.burst_done = 0;
  endtask
  task automatic pulse_wr_start();
    wr_frame_start = 1;
    @(negedge core_clk);
    wr_frame_start = 0;
  endtask
  typedef struct { logic wr, rd, exp_w; logic [27:0] exp_a; } vec_t;
  vec_t tbl[8];
  logic w;
  logic [27:0] a;
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{1, 1, 0, 28'h080_0000};
    tbl[1] = '{1, 1, 1, 28'h000_0000};
    tbl[2] = '{1, 1, 0, 28'h080_0400};
    tbl[3] = '{1, 1, 1, 28'h000_0400};
    tbl[4] = '{1, 1, 0, 28'h080_0800};
    tbl[5] = '{1, 1, 1, 28'h000_0800};
    tbl[6] = '{1, 0, 1, 28'h000_0C00};
    tbl[7] = '{0, 1, 0, 28'h080_0C00};
    cmd.cmd_ready = 0;
    cmd.burst_done = 0;
    wr_req = 1;
    rd_req = 1;
    repeat (2) @(negedge core_clk);
    chk_en = 1;
    check("rst_cmd_valid", cmd.cmd_valid, 0);
    check("rst_cmd_addr", cmd.cmd_addr, 0);
    check("rst_wr_buf", wr_buf_idx, 0);
    check("rst_rd_buf", rd_buf_idx, 2);
    check("rst_cmd_len", cmd.cmd_len, 63);
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      wr_req = tbl[i].wr;
      rd_req = tbl[i].rd;
      burst(3, w, a);
      check($sformatf("tbl%0d_write", i), w, tbl[i].exp_w);
      check($sformatf("tbl%0d_addr", i), a, tbl[i].exp_a);
    end
    rst = 1;
    wr_req = 0;
    rd_req = 0;
    @(negedge core_clk);
    rst = 0;
    wr_req = 1;
    for (int i = 0; i < FB; i++) burst(1, w, a);
    check("full_last_addr", a, 28'h03F_4400);
    wr_req = 0;
    pulse_wr_start();
    check("full_wr_buf", wr_buf_idx, 1);
    check("full_no_drop", frame_drop, 0);
    rd_req = 1;
    wait_valid();
    check("defer_addr", cmd.cmd_addr, 28'h080_0000);
    cmd.cmd_ready = 1;
    @(negedge core_clk);
    cmd.cmd_ready = 0;
    rd_req = 0;
    rd_frame_start = 1;
    @(negedge core_clk);
    rd_frame_start = 0;
    check("defer_hold0", rd_buf_idx, 2);
    @(negedge core_clk);
    check("defer_hold1", rd_buf_idx, 2);
    cmd.burst_done = 1;
    @(negedge core_clk);
    cmd.burst_done = 0;
    check("defer_apply", rd_buf_idx, 0);
    rd_req = 1;
    burst(1, w, a);
    check("defer_next_addr", a, 28'h000_0000);
    rd_req = 0;
    wr_req = 1;
    for (int i = 0; i < 100; i++) burst(1, w, a);
    wr_req = 0;
    pulse_wr_start();
    check("short_drop", frame_drop, 1);
    check("short_wr_buf", wr_buf_idx, 1);
    @(negedge core_clk);
    check("short_drop_once", frame_drop, 0);
    wr_req = 1;
    burst(1, w, a);
    check("short_restart_addr", a, 28'h040_0000);
    for (int i = 1; i < FB; i++) burst(1, w, a);
    wr_req = 0;
    pulse_wr_start();
    check("second_wr_buf", wr_buf_idx, 2);
    wr_req = 1;
    for (int i = 0; i < FB; i++) burst(1, w, a);
    wr_req = 0;
    wr_frame_start = 1;
    rd_frame_start = 1;
    @(negedge core_clk);
    wr_frame_start = 0;
    rd_frame_start = 0;
    check("simul_rd_buf", rd_buf_idx, 1);
    check("simul_wr_buf", wr_buf_idx, 0);
    check("simul_no_drop", frame_drop, 0);
    rd_req = 1;
    burst(1, w, a);
    check("simul_rd_addr", a, 28'h040_0000);
    rd_req = 0;
    wr_req = 1;
    burst(1, w, a);
    check("simul_wr_addr", a, 28'h000_0000);
    check("simul_wr_dir", w, 1);
    rst = 1;
    @(negedge core_clk);
    rst = 0;
    for (int i = 0; i < 4000; i++) begin
      wr_req = $urandom_range(0, 9) < 7;
      rd_req = $urandom_range(0, 9) < 7;
      cmd.cmd_ready = $urandom_range(0, 1);
      cmd.burst_done = $urandom_range(0, 3) == 0;
      wr_frame_start = $urandom_range(0, 49) == 0;
      rd_frame_start = $urandom_range(0, 49) == 0;
      rst = $urandom_range(0, 299) == 0;
      @(negedge core_clk);
    end
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ddr_frame_arbiter.md
# ddr_frame_arbiter

Triple-buffered frame-store scheduler between the OV5640 capture path and the HDMI 1080P60 scan-out path. Arbitrates burst requests from the camera write FIFO and the HDMI read FIFO onto the single DDR3 controller command port. Generates burst addresses and rotates three frame buffers so the reader never scans a buffer being written. Sits in the `core_clk` domain. Frame-start pulses arrive already synchronised from the camera and HDMI timing domains.

## Interface
- `ADDR_W`, 28: byte address width of the DDR command port.
- `BURST_LEN`, 64: beats per burst; `cmd_len` carries BURST_LEN-1.
- `BEAT_BYTES`, 16: bytes per beat (128-bit user bus).
- `FRAME_BURSTS`, 4050: bursts per frame (1920×1080×2 B / 1024 B).
- `FB_BASE`, 0: byte address of buffer 0.
- `FB_STRIDE`, 32'h0040_0000: byte distance between buffers.

Ports:
- `core_clk` in 1: the single clock for the block.
- `rst` in 1: synchronous, active-high reset.
- `wr_frame_start` in 1: one-cycle pulse at camera VSYNC.
- `wr_req` in 1: camera FIFO holds ≥ one burst.
- `rd_frame_start` in 1: one-cycle pulse at HDMI VSYNC.
- `rd_req` in 1: HDMI FIFO has room for ≥ one burst.
- `cmd_valid` out 1: burst command valid.
- `cmd_ready` in 1: controller accepts the command.
- `cmd_write` out 1: 1 means write (camera), 0 means read (HDMI).
- `cmd_addr` out ADDR_W: burst byte address.
- `cmd_len` out 8: BURST_LEN-1, constant.
- `burst_done` in 1: one-cycle pulse when all data of the outstanding burst has moved.
- `wr_buf_idx` out 2: buffer currently being written.
- `rd_buf_idx` out 2: buffer currently being read.
- `frame_drop` out 1: one-cycle pulse when an incomplete write frame is discarded.

## Operation
- FSM has three states: IDLE, ISSUE, WAIT_DONE. Only one burst is outstanding in total.
- IDLE, request evaluation:
  - Write is eligible when `wr_req` && `wr_off` < FRAME_BURSTS.
  - Read is eligible when `rd_req` && `rd_off` < FRAME_BURSTS.
- IDLE, grant:
  - One eligible channel: grant it.
  - Both eligible: grant the channel not granted last (round-robin). After reset, read wins.
  - On a grant, latch `cmd_write` and `cmd_addr`, then move to ISSUE.
- Address: `cmd_addr` = FB_BASE + buf×FB_STRIDE + off×BURST_LEN×BEAT_BYTES, truncated to ADDR_W.
  - buf×FB_STRIDE is a 3-way constant mux; no multiplier.
  - The offset term is a shift; BURST_LEN×BEAT_BYTES must be a power of two.
- ISSUE: hold `cmd_valid`=1 with stable fields until `cmd_ready`, then go to WAIT_DONE.
- WAIT_DONE:
  - On `burst_done`, increment the granted channel's offset and return to IDLE.
  - `burst_done` in any other state is ignored.
- Write frame start (`wr_frame_start`):
  - If `wr_off` == FRAME_BURSTS: `latest` := `wr_buf`, then `wr_buf` := the lowest index ∉ {new `latest`, `rd_buf`}.
  - Otherwise: pulse `frame_drop` and keep `wr_buf`.
  - In both cases `wr_off` := 0.
- Read frame start (`rd_frame_start`): `rd_buf` := `latest`, `rd_off` := 0.
- Frame start while that channel's burst is in ISSUE or WAIT_DONE:
  - Record a pending flag.
  - Apply the update in the cycle `burst_done` is taken. The offset is cleared rather than incremented.
  - A second pulse while pending is merged into the first.
- Simultaneous `wr_frame_start` and `rd_frame_start`: apply the read update first, then select the write buffer using the new `rd_buf`.
- Invariant: `wr_buf` ≠ `rd_buf` at all times.
- Reset values:
  - `wr_buf`=0, `latest`=2, `rd_buf`=2, both offsets 0, state IDLE.
  - `cmd_valid`=0, `cmd_write`=0, `cmd_addr`=0, `frame_drop`=0, last-grant=write.

## Timing
- Eligible request in IDLE at cycle N gives `cmd_valid`=1 at N+1, the same cycle as ISSUE.
- A `cmd_ready` handshake at cycle M moves the FSM to WAIT_DONE at M+1.
- `burst_done` at cycle K returns the FSM to IDLE at K+1. The next `cmd_valid` can assert at K+2.
- `wr_buf_idx`, `rd_buf_idx` and `frame_drop` are registered and update one cycle after the triggering event (the pulse, or `burst_done` for deferred updates).
- Synchronous `rst` mid-burst: everything returns to reset values at the next edge, including dropping `cmd_valid`. Recovering the DDR controller is outside this block.
- `cmd_len` is tied to BURST_LEN-1 and is valid from reset.

## Test plan
- Reset: after `rst` with `wr_req`=`rd_req`=1, the first command is a read at address FB_BASE+2×FB_STRIDE=0x0080_0000. The next command is a write at 0x0000_0000. Both require `cmd_ready`=1 and `burst_done` 3 cycles after acceptance.
- Round-robin:
  - Both requests held high for 8 bursts: `cmd_write` alternates 0,1,0,1…
  - Write offsets step 0x400 per write burst; read offsets step 0x400 per read burst.
- Full write frame: 4050 write bursts, then `wr_frame_start` gives `latest`=0 and `wr_buf_idx`=1 with no `frame_drop`. A following `rd_frame_start` gives `rd_buf_idx`=0 and the next read address 0x0000_0000.
- Short write frame: `wr_frame_start` after 100 write bursts pulses `frame_drop` once. `wr_buf_idx` is unchanged and the next write address returns to the buffer base.
- Deferred start: `rd_frame_start` while a read is in WAIT_DONE leaves `rd_buf_idx` unchanged until one cycle after `burst_done`. The next read uses offset 0 of `latest`.
- Simultaneous starts with `latest`=1, `rd_buf`=0, `wr_buf`=2 and a complete write frame:
  - Result: `rd_buf`=1, `latest`=2, `wr_buf`=0.
  - Check that `wr_buf` ≠ `rd_buf` every cycle.
